rice_core_id_stage: RTL and testbench
=====================================

# rice_core_id_stage

Instruction-decode stage of the rice core, directly downstream of the IF stage. It consumes the fetched `{valid, pc, inst}` stream and decodes each RV32I instruction. It reads source operands from an internal 32-entry register file and presents a registered decode result to the EX stage. It owns IF back-pressure (`stall`), load-use bubble insertion and flush squashing of the decode register.

## Interface
- `XLEN`, 32, data/address width; only 32 is supported.
- `i_clk`  in  1  core clock; all state updates on its rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_enable`  in  1  core enable; low squashes `id_result.valid` and writes nothing.
- `pipeline_if` (`rice_core_pipeline_if.id_stage`): bundle of the signals below.
- `pipeline_if.if_result`  in  1+XLEN+32  `{valid, pc, inst}` from the IF stage.
- `pipeline_if.stall`  out  1  IF must hold its current head entry.
- `pipeline_if.flush`  in  1  redirect from EX; kills the instruction in ID.
- `pipeline_if.ex_stall`  in  1  EX cannot accept a new `id_result` this cycle.
- `pipeline_if.wb_result`  in  1+5+XLEN  `{valid, rd, value}` register write-back.
- `pipeline_if.id_result`  out  struct  `{valid, pc, inst, rd, rd_write, rs1, rs2, rs1_value, rs2_value, imm, alu_op, is_load, is_store, is_branch, is_jal, is_jalr, illegal}`.

## Operation
- Decode register update, in priority order:
  - `!i_rst_n`: all `id_result` fields are 0.
  - `!i_enable || flush`: `valid` goes to 0; other fields don't care.
  - `ex_stall && id_result.valid`: hold every field. Exception: on `wb_result.valid` with `rd != 0` matching the held `rs1`/`rs2`, overwrite that operand value.
  - `load_use`: `valid` goes to 0, producing a bubble.
  - Otherwise: `valid <= if_result.valid`, and all fields load from the decoder.
- `load_use` = `if_result.valid && id_result.valid && id_result.is_load && id_result.rd != 0` and the incoming instruction uses `rs1` or `rs2` equal to `id_result.rd`.
  - Operand use is per format: R, S and B formats use `rs1` and `rs2`; I format and JALR use `rs1`; U format and JAL use neither.
- `stall = if_result.valid && ((ex_stall && id_result.valid) || load_use)`. The IF pop condition is `valid && !stall`, so an instruction is accepted exactly when it is loaded into the decode register.
- Immediates are sign-extended from `inst[31]`: I `{inst[31:20]}`, S `{inst[31:25], inst[11:7]}`, B `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`, U `{inst[31:12], 12'b0}`, J `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
  - Any other opcode, or an `inst[1:0] != 2'b11`, sets `illegal=1`, `rd_write=0`, `is_*=0`.
  - `rd_write=0` whenever `rd == 0`.
- Register file: x1..x31, XLEN wide, reset to 0. It is written on `wb_result.valid && rd != 0`.
  - x0 reads as 0.
  - A read of the register being written in the same cycle returns `wb_result.value` (write-through bypass).

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on `id_result` after edge N, with `rs*_value` reflecting all write-backs up to and including cycle N.
- `stall` and `load_use` are combinational from `if_result`, `id_result` and `ex_stall`. There is no combinational path from `flush` to `stall`.
- Flush in the same cycle as `ex_stall` or `load_use`: flush wins and `valid=0`.
  - `stall` may still assert that cycle. IF clears its FIFO on flush, so this is harmless.
- A load-use bubble lasts exactly one cycle. In the next cycle `id_result` is the bubble, so `load_use` drops and the held instruction enters.
- Reset mid-operation: the decode register and register file clear on the next edge. `stall=0` while `if_result.valid=0`.

## Structure
- `rice_core_pkg` owns the shared definitions:
  - the `rice_core_id_result` struct;
  - the `rice_core_alu_op` enum;
  - the opcode constants;
  - the `get_imm()` function.
- The decode struct fields are also added to the `rice_core_define_types(XLEN)` macro.
- Sub-module `rice_core_register_file`: parameters `XLEN`; 2 read ports and 1 write port, synchronous reset, x0 hard-wired to zero, write-through bypass.
- The decoder is a combinational `always_comb` block in the stage.

## Test plan
- Reset: `i_rst_n=0` for 2 cycles, then run. Required: `id_result.valid=0`, `stall=0`, and a read of x5 returns 0.
- Decode: `if_result={1, 0x8000_0000, 0xFFF0_0093}` (`addi x1,x0,-1`). Required next cycle: `valid=1`, `rd=1`, `imm=0xFFFF_FFFF`, `rd_write=1`, `illegal=0`.
- Load-use: `lw x2,0(x1)` followed by `add x3,x2,x2`. Required: `stall=1` for one cycle, then one `id_result` bubble, then the `add` with `rs1=rs2=2`.
- EX stall hold-and-update: `ex_stall=1` for 3 cycles with the `add x3,x1,x1` held, and `wb_result={1, 1, 0x1234}` in cycle 2. Required: `id_result` is unchanged except `rs1_value=rs2_value=0x1234`, and `stall=1` throughout.
- Flush: `flush=1` together with `ex_stall=1`. Required next cycle: `valid=0`. Also, `wb_result={1, 0, 0xDEAD}` leaves x0 reading 0.
- Illegal opcode: `inst=0x0000_0000`. Required: `valid=1`, `illegal=1`, `rd_write=0`.

Source files
------------

// File: rtl/rice_core_pkg.sv
// rice_core_pkg: shared definitions for the rice core pipeline.
//   - opcode constants (RV32I major opcodes)
//   - rice_core_alu_op: ALU operation selected by the decoder
//   - rice_core_fmt: instruction encoding format, drives immediate extraction
//   - pipeline records: IF result, WB result, ID result
//   - get_imm(): sign-extended immediate for a given format
// Width-parameterised copies of the pipeline records are available through
// the RICE_CORE_DEFINE_TYPES(XLEN) macro for blocks that need XLEN != 32.

`define RICE_CORE_DEFINE_TYPES(XLEN) \
    typedef struct packed { \
        logic valid; logic [XLEN-1:0] pc; logic [31:0] inst; \
    } if_result_t; \
    typedef struct packed { \
        logic valid; logic [4:0] rd; logic [XLEN-1:0] value; \
    } wb_result_t; \
    typedef struct packed { \
        logic valid; logic [XLEN-1:0] pc; logic [31:0] inst; \
        logic [4:0] rd; logic rd_write; logic [4:0] rs1; logic [4:0] rs2; \
        logic [XLEN-1:0] rs1_value; logic [XLEN-1:0] rs2_value; logic [XLEN-1:0] imm; \
        rice_core_pkg::rice_core_alu_op alu_op; \
        logic is_load; logic is_store; logic is_branch; logic is_jal; logic is_jalr; \
        logic illegal; \
    } id_result_t;

package rice_core_pkg;

    localparam int RICE_XLEN = 32;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } rice_core_alu_op;

    // FMT_X marks an unsupported encoding (no immediate, no operands)
    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } rice_core_fmt;

    typedef struct packed {
        logic                 valid;
        logic [RICE_XLEN-1:0] pc;
        logic [31:0]          inst;
    } rice_core_if_result;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           rd;
        logic [RICE_XLEN-1:0] value;
    } rice_core_wb_result;

    typedef struct packed {
        logic                 valid;
        logic [RICE_XLEN-1:0] pc;
        logic [31:0]          inst;
        logic [4:0]           rd;
        logic                 rd_write;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [RICE_XLEN-1:0] rs1_value;
        logic [RICE_XLEN-1:0] rs2_value;
        logic [RICE_XLEN-1:0] imm;
        rice_core_alu_op      alu_op;
        logic                 is_load;
        logic                 is_store;
        logic                 is_branch;
        logic                 is_jal;
        logic                 is_jalr;
        logic                 illegal;
    } rice_core_id_result;

    // Only inst[31:7] carries immediate bits; the opcode field is not needed.
    function automatic logic [31:0] get_imm(input logic [31:7] inst, input rice_core_fmt fmt);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rice_core_pipeline_if.sv
// rice_core_pipeline_if: IF/ID/EX/WB handshake bundle seen by the decode stage.
//   if_result  IF -> ID   {valid, pc, inst}
//   stall      ID -> IF   hold the current head entry
//   flush      EX -> ID   kill the instruction in ID
//   ex_stall   EX -> ID   EX cannot take a new id_result
//   wb_result  WB -> ID   {valid, rd, value} register write-back
//   id_result  ID -> EX   registered decode record

interface rice_core_pipeline_if;

    rice_core_pkg::rice_core_if_result if_result;
    logic                              stall;
    logic                              flush;
    logic                              ex_stall;
    rice_core_pkg::rice_core_wb_result wb_result;
    rice_core_pkg::rice_core_id_result id_result;

    modport id_stage (
        input  if_result,
        input  flush,
        input  ex_stall,
        input  wb_result,
        output stall,
        output id_result
    );

endinterface

// File: rtl/rice_core_register_file.sv
// rice_core_register_file: 32 x XLEN integer register file.
//   i_clk, i_rst_n     clock, synchronous active-low reset (clears all entries)
//   rs1, rs2           read addresses
//   rs1_value/rs2_value combinational read data; x0 reads 0
//   we, rd, rd_value   write port; writes to x0 are dropped
// A read of the register being written this cycle returns rd_value, so the
// decode register captures the value that lands on the same edge.

module rice_core_register_file #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rs1_value,
    output logic [XLEN-1:0] rs2_value,
    input  logic            we,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] rd_value
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && rd != 5'd0) begin
            regs[rd] <= rd_value;
        end
    end

    // rs != 0 together with rd == rs already excludes a bypass of x0
    always_comb begin
        rs1_value = '0;
        rs2_value = '0;
        if (rs1 != 5'd0) rs1_value = (we && rd == rs1) ? rd_value : regs[rs1];
        if (rs2 != 5'd0) rs2_value = (we && rd == rs2) ? rd_value : regs[rs2];
    end

endmodule

// File: rtl/rice_core_id_stage.sv
// rice_core_id_stage: RV32I instruction decode stage.
//   i_clk       core clock
//   i_rst_n     synchronous active-low reset
//   i_enable    core enable; low squashes id_result.valid and blocks RF writes
//   pipeline_if id_stage modport: if_result/flush/ex_stall/wb_result in,
//               stall/id_result out
// Decodes the IF head combinationally, reads operands from the internal
// register file and registers the result for EX. Owns IF back-pressure,
// load-use bubbles and flush squashing of the decode register.

module rice_core_id_stage
    import rice_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    rice_core_pipeline_if.id_stage pipeline_if
);

    rice_core_if_result if_result;
    rice_core_wb_result wb_result;
    rice_core_id_result dec;
    rice_core_id_result id_q;
    rice_core_fmt       fmt;
    logic               uses_rs1;
    logic               uses_rs2;
    logic [XLEN-1:0]    rf_rs1_value;
    logic [XLEN-1:0]    rf_rs2_value;
    logic               rf_we;
    logic               hold;
    logic               load_use;

    assign if_result = pipeline_if.if_result;
    assign wb_result = pipeline_if.wb_result;
    assign rf_we     = i_enable && wb_result.valid;

    rice_core_register_file #(
        .XLEN(XLEN)
    ) u_rf (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .rs1      (if_result.inst[19:15]),
        .rs2      (if_result.inst[24:20]),
        .rs1_value(rf_rs1_value),
        .rs2_value(rf_rs2_value),
        .we       (rf_we),
        .rd       (wb_result.rd),
        .rd_value (wb_result.value)
    );

    // inst[30] selects SUB for register ops and SRA for both shift forms;
    // ADDI ignores it because that bit is part of its immediate.
    function automatic rice_core_alu_op alu_decode(input logic [2:0] funct3,
                                                   input logic alt,
                                                   input logic is_reg);
        case (funct3)
            3'd0:    return (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Decoder. Every opcode constant ends in 2'b11, so a compressed-looking
    // encoding falls through to FMT_X and is flagged illegal.
    always_comb begin
        dec           = '0;
        fmt           = FMT_X;
        dec.valid     = if_result.valid;
        dec.pc        = if_result.pc;
        dec.inst      = if_result.inst;
        dec.rd        = if_result.inst[11:7];
        dec.rs1       = if_result.inst[19:15];
        dec.rs2       = if_result.inst[24:20];
        dec.rs1_value = rf_rs1_value;
        dec.rs2_value = rf_rs2_value;
        dec.alu_op    = ALU_ADD;
        case (if_result.inst[6:0])
            OPC_LUI, OPC_AUIPC: fmt = FMT_U;
            OPC_JAL: begin
                fmt        = FMT_J;
                dec.is_jal = 1'b1;
            end
            OPC_JALR: begin
                fmt         = FMT_I;
                dec.is_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                fmt           = FMT_B;
                dec.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                fmt         = FMT_I;
                dec.is_load = 1'b1;
            end
            OPC_STORE: begin
                fmt          = FMT_S;
                dec.is_store = 1'b1;
            end
            OPC_OP_IMM: begin
                fmt        = FMT_I;
                dec.alu_op = alu_decode(if_result.inst[14:12], if_result.inst[30], 1'b0);
            end
            OPC_OP: begin
                fmt        = FMT_R;
                dec.alu_op = alu_decode(if_result.inst[14:12], if_result.inst[30], 1'b1);
            end
            OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
            default: ;
        endcase
        dec.illegal  = (fmt == FMT_X);
        dec.imm      = get_imm(if_result.inst[31:7], fmt);
        // S and B formats have no destination; the rd field holds imm bits
        dec.rd_write = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (dec.rd != 5'd0);
        uses_rs1     = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
        uses_rs2     = fmt inside {FMT_R, FMT_S, FMT_B};
    end

    assign hold     = pipeline_if.ex_stall && id_q.valid;
    assign load_use = if_result.valid && id_q.valid && id_q.is_load && (id_q.rd != 5'd0) &&
                      ((uses_rs1 && dec.rs1 == id_q.rd) || (uses_rs2 && dec.rs2 == id_q.rd));

    // Deliberately independent of flush: IF drops its FIFO on flush anyway.
    assign pipeline_if.stall = if_result.valid && (hold || load_use);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            id_q <= '0;
        end else if (!i_enable || pipeline_if.flush) begin
            id_q.valid <= 1'b0;
        end else if (hold) begin
            // A held instruction must still see write-backs that land while it waits.
            if (wb_result.valid && wb_result.rd != 5'd0 && wb_result.rd == id_q.rs1)
                id_q.rs1_value <= wb_result.value;
            if (wb_result.valid && wb_result.rd != 5'd0 && wb_result.rd == id_q.rs2)
                id_q.rs2_value <= wb_result.value;
        end else if (load_use) begin
            id_q.valid <= 1'b0;
        end else begin
            id_q <= dec;
        end
    end

    assign pipeline_if.id_result = id_q;

endmodule

// File: tb/tb_rice_core_id_stage.sv
module tb_rice_core_id_stage;
    import rice_core_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_enable;

    rice_core_pipeline_if pif ();

    rice_core_id_stage #(.XLEN(32)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_enable   (i_enable),
        .pipeline_if(pif)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                          input logic exs, input logic fl, input logic wv,
                          input logic [4:0] wrd, input logic [31:0] wval);
        pif.if_result.valid = v;
        pif.if_result.pc    = pc;
        pif.if_result.inst  = inst;
        pif.ex_stall        = exs;
        pif.flush           = fl;
        pif.wb_result.valid = wv;
        pif.wb_result.rd    = wrd;
        pif.wb_result.value = wval;
    endtask

    task automatic edge1();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_stall(input string nm, input logic want);
        @(negedge i_clk);
        chk(nm, 256'(pif.stall), 256'(want));
    endtask

    // ---------------- reference model ----------------
    rice_core_id_result m_id;
    logic [31:0]        m_rf [32];
    logic [6:0]         opc_tab [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                         7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    rice_core_alu_op    f3_ops [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                       ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

    function automatic rice_core_id_result ref_decode(input logic v, input logic [31:0] pc,
                                                      input logic [31:0] inst);
        rice_core_id_result r;
        logic [6:0] op = inst[6:0];
        logic [2:0] f3 = inst[14:12];
        r = '0;
        r.valid = v; r.pc = pc; r.inst = inst;
        r.rd = inst[11:7]; r.rs1 = inst[19:15]; r.rs2 = inst[24:20];
        r.rs1_value = m_rf[r.rs1];
        r.rs2_value = m_rf[r.rs2];
        r.alu_op = ALU_ADD;
        case (op)
            7'h37, 7'h17: r.imm = {inst[31:12], 12'h000};
            7'h6F: begin
                r.is_jal = 1'b1;
                r.imm = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            end
            7'h67: begin r.is_jalr = 1'b1; r.imm = 32'($signed(inst[31:20])); end
            7'h63: begin
                r.is_branch = 1'b1;
                r.imm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            end
            7'h03: begin r.is_load = 1'b1; r.imm = 32'($signed(inst[31:20])); end
            7'h23: begin r.is_store = 1'b1; r.imm = 32'($signed({inst[31:25], inst[11:7]})); end
            7'h13, 7'h33: begin
                if (op == 7'h13) r.imm = 32'($signed(inst[31:20]));
                r.alu_op = f3_ops[f3];
                if (inst[30] && f3 == 3'd5) r.alu_op = ALU_SRA;
                if (inst[30] && f3 == 3'd0 && op == 7'h33) r.alu_op = ALU_SUB;
            end
            7'h0F, 7'h73: r.imm = 32'($signed(inst[31:20]));
            default: r.illegal = 1'b1;
        endcase
        r.rd_write = !r.illegal && r.rd != 5'd0 && op != 7'h63 && op != 7'h23;
        return r;
    endfunction

    function automatic logic ref_lu(input logic ifv, input logic [31:0] inst);
        logic [6:0] op = inst[6:0];
        logic u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        logic u1 = u2 || op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h0F || op == 7'h73;
        return ifv && m_id.valid && m_id.is_load && m_id.rd != 5'd0 &&
               ((u1 && inst[19:15] == m_id.rd) || (u2 && inst[24:20] == m_id.rd));
    endfunction

    // imm and alu_op carry no meaning for an illegal instruction
    function automatic rice_core_id_result mask(input rice_core_id_result r);
        rice_core_id_result q = r;
        if (q.illegal) begin q.imm = '0; q.alu_op = ALU_ADD; end
        return q;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 12);
        if (k < 11) w[6:0] = opc_tab[k];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    // ---------------- decode vector table ----------------
    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        rw, il, ld, st, br, jal, jalr;
        logic [31:0] imm;
    } vec_t;
    vec_t tab [11];

    initial begin
        logic r_rst, r_en, r_fl, r_exs, r_wv, r_ifv, lu, e_stall, prev_hold;
        logic [4:0]  r_wrd;
        logic [31:0] r_wval, r_pc, r_inst, got_imm;

        tab[0]  = '{32'hFFF00093, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF};
        tab[1]  = '{32'h123452B7, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345000};
        tab[2]  = '{32'hFE20AE23, 5'd28, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC};
        tab[3]  = '{32'hFE208CE3, 5'd25, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFF8};
        tab[4]  = '{32'h001000EF, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000800};
        tab[5]  = '{32'h00408067, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000004};
        tab[6]  = '{32'h00000013, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000};
        tab[7]  = '{32'h00000000, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000};
        tab[8]  = '{32'h00000090, 5'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000};
        tab[9]  = '{32'hFFFFF397, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFF000};
        tab[10] = '{32'h0000A103, 5'd2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000};

        // reset
        i_rst_n = 1'b0;
        i_enable = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        edge1();
        edge1();
        chk("reset_valid", 256'(pif.id_result.valid), 256'(1'b0));
        chk_stall("reset_stall", 1'b0);
        i_rst_n = 1'b1;

        // x5 reads 0 after reset (addi x0,x5,0)
        set_in(1'b1, 32'h7FFF_FFFC, 32'h00028013, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        edge1();
        chk("x5_reset", 256'({pif.id_result.rs1, pif.id_result.rs1_value}), 256'({5'd5, 32'h0}));

        // addi x1,x0,-1
        set_in(1'b1, 32'h8000_0000, 32'hFFF00093, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        edge1();
        chk("addi_decode",
            256'({pif.id_result.valid, pif.id_result.pc, pif.id_result.rd, pif.id_result.imm,
                  pif.id_result.rd_write, pif.id_result.illegal}),
            256'({1'b1, 32'h8000_0000, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0}));

        // table of single-instruction decodes; the load is last on purpose
        for (int i = 0; i < 11; i++) begin
            set_in(1'b1, 32'h100 + 32'(i * 4), tab[i].inst, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            edge1();
            got_imm = tab[i].il ? 32'h0 : pif.id_result.imm;
            chk($sformatf("vec%0d", i),
                256'({pif.id_result.valid, pif.id_result.rd, pif.id_result.rd_write,
                      pif.id_result.illegal, pif.id_result.is_load, pif.id_result.is_store,
                      pif.id_result.is_branch, pif.id_result.is_jal, pif.id_result.is_jalr, got_imm}),
                256'({1'b1, tab[i].rd, tab[i].rw, tab[i].il, tab[i].ld, tab[i].st,
                      tab[i].br, tab[i].jal, tab[i].jalr, tab[i].imm}));
        end

        // load-use: lw x2,0(x1) is in ID, add x3,x2,x2 arrives
        set_in(1'b1, 32'h200, 32'h002101B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk_stall("lu_stall", 1'b1);
        edge1();
        chk("lu_bubble", 256'(pif.id_result.valid), 256'(1'b0));
        chk_stall("lu_stall_drop", 1'b0);
        edge1();
        chk("lu_add", 256'({pif.id_result.valid, pif.id_result.inst, pif.id_result.rs1, pif.id_result.rs2}),
            256'({1'b1, 32'h002101B3, 5'd2, 5'd2}));

        // ex_stall hold with write-back update: add x3,x1,x1
        set_in(1'b1, 32'h300, 32'h001081B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        edge1();
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, 32'h304, 32'h00000013, 1'b1, 1'b0, c == 1, 5'd1, 32'h1234);
            chk_stall($sformatf("hold_stall%0d", c), 1'b1);
            edge1();
            chk($sformatf("hold_fields%0d", c),
                256'({pif.id_result.valid, pif.id_result.pc, pif.id_result.inst, pif.id_result.rd,
                      pif.id_result.rs1, pif.id_result.rs2, pif.id_result.rd_write}),
                256'({1'b1, 32'h300, 32'h001081B3, 5'd3, 5'd1, 5'd1, 1'b1}));
            if (c == 0)
                chk("hold_pre_wb", 256'({pif.id_result.rs1_value, pif.id_result.rs2_value}), 256'({32'h0, 32'h0}));
        end
        chk("hold_wb_update", 256'({pif.id_result.rs1_value, pif.id_result.rs2_value}),
            256'({32'h1234, 32'h1234}));

        // flush beats ex_stall; write to x0 is dropped
        set_in(1'b1, 32'h304, 32'h00000013, 1'b1, 1'b1, 1'b1, 5'd0, 32'hDEAD);
        edge1();
        chk("flush_valid", 256'(pif.id_result.valid), 256'(1'b0));
        set_in(1'b1, 32'h400, 32'h000001B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        edge1();
        chk("x0_zero", 256'({pif.id_result.valid, pif.id_result.rs1_value, pif.id_result.rs2_value}),
            256'({1'b1, 32'h0, 32'h0}));
        set_in(1'b1, 32'h404, 32'h001081B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        edge1();
        chk("x1_written", 256'(pif.id_result.rs1_value), 256'(32'h1234));

        // enable low squashes valid
        i_enable = 1'b0;
        set_in(1'b1, 32'h408, 32'h00000013, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        edge1();
        chk("enable_low", 256'(pif.id_result.valid), 256'(1'b0));
        i_enable = 1'b1;

        // randomized run against the reference model
        i_rst_n = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        edge1();
        m_id = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        prev_hold = 1'b0;
        r_pc = 32'h1000;
        r_ifv = 1'b0;
        r_inst = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            r_rst  = $urandom_range(0, 149) != 0;
            r_en   = $urandom_range(0, 19) != 0;
            r_fl   = $urandom_range(0, 15) == 0;
            r_exs  = $urandom_range(0, 3) == 0;
            r_wv   = $urandom_range(0, 1) == 1;
            r_wrd  = 5'($urandom_range(0, 3));
            r_wval = $urandom;
            if (!prev_hold) begin
                r_ifv  = $urandom_range(0, 3) != 0;
                r_pc   = r_pc + 32'd4;
                r_inst = rand_inst();
            end
            i_rst_n  = r_rst;
            i_enable = r_en;
            set_in(r_ifv, r_pc, r_inst, r_exs, r_fl, r_wv, r_wrd, r_wval);
            lu      = ref_lu(r_ifv, r_inst);
            e_stall = r_ifv && ((r_exs && m_id.valid) || lu);
            chk_stall("rand_stall", e_stall);
            @(posedge i_clk);
            if (!r_rst) begin
                m_id = '0;
                for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
            end else begin
                if (r_en && r_wv && r_wrd != 5'd0) m_rf[r_wrd] = r_wval;
                if (!r_en || r_fl) m_id.valid = 1'b0;
                else if (r_exs && m_id.valid) begin
                    if (r_wv && r_wrd != 5'd0 && r_wrd == m_id.rs1) m_id.rs1_value = r_wval;
                    if (r_wv && r_wrd != 5'd0 && r_wrd == m_id.rs2) m_id.rs2_value = r_wval;
                end else if (lu) m_id.valid = 1'b0;
                else m_id = ref_decode(r_ifv, r_pc, r_inst);
            end
            #1;
            chk("rand_valid", 256'(pif.id_result.valid), 256'(m_id.valid));
            if (m_id.valid)
                chk("rand_fields", 256'(mask(pif.id_result)), 256'(mask(m_id)));
            prev_hold = e_stall && r_rst && r_en && !r_fl;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
